// File: rtl/sram_1w1r_bypass.sv
// sram_1w1r_bypass
//   Behavioural single-clock SRAM with one write port (port 0) and one read
//   port (port 1). Each write lane can be masked on its own. The read latency
//   is selectable (1 or 2 edges). A read of the address being written at the
//   same edge can return either the new data (bypass) or the old data.
//   Every completed read raises dout1_valid for one cycle. If that read met a
//   same-edge write to its address, collision1 is raised with it.
//
// Parameters
//   DATA_WIDTH    data bits per word
//   ADDR_WIDTH    address bits; depth = 1 << ADDR_WIDTH
//   NUM_LANES     number of write-mask lanes; must divide DATA_WIDTH
//   READ_LATENCY  edges from read request to dout1 update (1 or 2)
//   BYPASS        1: a colliding read returns the merged new word
//                 0: a colliding read returns the old word
//
// Ports
//   clk0         clock shared by both ports
//   rst0         asynchronous reset, active high; the memory array keeps its contents
//   csb0         write select, active low
//   addr0        write address
//   din0         write data
//   wmask0       per-lane write enable
//   csb1         read select, active low
//   addr1        read address
//   dout1        read data; holds its value between reads
//   dout1_valid  one-cycle pulse per completed read
//   collision1   qualifies dout1_valid: that read hit a same-edge write

module sram_1w1r_bypass #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int NUM_LANES    = 4,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [NUM_LANES-1:0]  wmask0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_valid,
    output logic                  collision1
);

    localparam int LANE_WIDTH = DATA_WIDTH / NUM_LANES;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sram_1w1r_bypass: READ_LATENCY must be 1 or 2, got %0d", READ_LATENCY);
    end

    if ((DATA_WIDTH % NUM_LANES) != 0) begin : g_bad_lanes
        $error("sram_1w1r_bypass: DATA_WIDTH (%0d) not divisible by NUM_LANES (%0d)",
               DATA_WIDTH, NUM_LANES);
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  write_active;
    logic                  read_active;
    logic                  collide;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] read_word;

    logic                  s1_valid;
    logic                  s1_coll;
    logic [DATA_WIDTH-1:0] s1_data;

    logic                  fin_valid;
    logic                  fin_coll;
    logic [DATA_WIDTH-1:0] fin_data;

    // An all-zero mask is not a real write, so it never counts as a collision.
    assign write_active = !csb0 && (|wmask0);
    assign read_active  = !csb1;
    assign collide      = write_active && read_active && (addr0 == addr1);

    // Read path for the current edge. The merged word is what the array will
    // hold after this edge's write, so bypass returns exactly that.
    always_comb begin
        old_word    = mem[addr1];
        merged_word = old_word;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wmask0[i]) begin
                merged_word[i*LANE_WIDTH +: LANE_WIDTH] = din0[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        read_word = ((BYPASS != 0) && collide) ? merged_word : old_word;
    end

    // The array has no reset, so its contents survive rst0. Writes are only
    // blocked while rst0 is held.
    always_ff @(posedge clk0) begin
        if (!rst0 && !csb0) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (wmask0[i]) begin
                    mem[addr0][i*LANE_WIDTH +: LANE_WIDTH] <= din0[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Stage 1 captures the word at the request edge. With READ_LATENCY=2,
    // a write at the following edge therefore cannot change what is returned.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            s1_valid <= 1'b0;
            s1_coll  <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= read_active;
            s1_coll  <= collide;
            if (read_active) begin
                s1_data <= read_word;
            end
        end
    end

    always_comb begin
        fin_valid = read_active;
        fin_coll  = collide;
        fin_data  = read_word;
        if (READ_LATENCY == 2) begin
            fin_valid = s1_valid;
            fin_coll  = s1_coll;
            fin_data  = s1_data;
        end
    end

    // dout1 only moves when a read completes. Valid and collision follow the
    // completing read every cycle, so each read gives exactly one pulse.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            dout1       <= '0;
            dout1_valid <= 1'b0;
            collision1  <= 1'b0;
        end else begin
            dout1_valid <= fin_valid;
            collision1  <= fin_valid && fin_coll;
            if (fin_valid) begin
                dout1 <= fin_data;
            end
        end
    end

endmodule
